debug_tx_arbiter: RTL and testbench

Round-robin arbiter that shares the single debug TX byte stream (into the UART TX FIFO) between N byte-stream requesters, e.g. per-core debug cores. It grants one requester at a time for a whole message, optionally prefixes each message with a channel tag byte, and releases on end-of-line, burst limit or idle timeout. It sits between the requesters' `fifo_tx_vld/dat/rdy` outputs and the shared TX FIFO.

---
 rtl/debug_tx_arbiter.sv | 135 +++++++++++++
 tb/tb_debug_tx_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_tx_arbiter.sv
// Round-robin arbiter sharing one debug TX byte stream among 2**IDW requesters.
// Grants a requester for a whole message, optionally prefixes a channel tag byte.

module debug_tx_arbiter_lane #(
  parameter int IDW  = 2,
  parameter int LANE = 0
) (
  input  logic           data_st_i,
  input  logic [IDW-1:0] gnt_i,
  input  logic           tx_rdy_i,
  output logic           req_rdy_o
);
  assign req_rdy_o = data_st_i && (gnt_i == IDW'(LANE)) && tx_rdy_i;
endmodule

module debug_tx_arbiter #(
  parameter int         IDW          = 2,
  parameter int         MAX_BURST    = 64,
  parameter int         IDLE_TIMEOUT = 16,
  parameter bit         TAG_EN       = 1'b1,
  parameter logic [7:0] EOL          = 8'h0A
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2**IDW-1:0]    req_vld,
  input  logic [8*2**IDW-1:0]  req_dat,
  output logic [2**IDW-1:0]    req_rdy,
  output logic                 tx_vld,
  output logic [7:0]           tx_dat,
  input  logic                 tx_rdy,
  output logic                 busy,
  output logic [IDW-1:0]       grant_id
);
  localparam int N = 2**IDW;

  typedef enum logic [1:0] {S_IDLE, S_TAG, S_DATA} state_t;

  state_t           state_q;
  logic [IDW-1:0]   ptr_q, gid_q;
  logic [7:0]       byte_cnt_q, idle_cnt_q;
  logic [7:0]       byte_cnt_d, idle_cnt_d;

  logic [N-1:0][7:0] dat_a;
  logic              sel_vld;
  logic [7:0]        sel_dat;
  logic              data_st, xfer, rel_xfer, rel_idle;
  logic              pick_vld;
  logic [IDW-1:0]    pick_id, idx;

  assign dat_a   = req_dat;
  assign sel_vld = req_vld[gid_q];
  assign sel_dat = dat_a[gid_q];
  assign data_st = (state_q == S_DATA);

  // Search ptr+1 .. ptr+N; iterating downward lets the nearest hit win.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = ptr_q;
    idx      = ptr_q;
    for (int k = N; k >= 1; k--) begin
      idx = ptr_q + IDW'(k);
      if (req_vld[idx]) begin
        pick_vld = 1'b1;
        pick_id  = idx;
      end
    end
  end

  always_comb begin
    tx_vld = 1'b0;
    tx_dat = 8'h00;
    case (state_q)
      S_TAG: begin
        tx_vld = 1'b1;
        tx_dat = 8'h80 | 8'(gid_q);
      end
      S_DATA: begin
        tx_vld = sel_vld;
        tx_dat = sel_dat;
      end
      default: ;
    endcase
  end

  assign xfer       = tx_vld && tx_rdy;
  assign byte_cnt_d = byte_cnt_q + 8'd1;
  assign idle_cnt_d = idle_cnt_q + 8'd1;
  assign rel_xfer   = data_st && xfer && ((sel_dat == EOL) || (byte_cnt_d == 8'(MAX_BURST)));
  assign rel_idle   = data_st && !sel_vld && (idle_cnt_d == 8'(IDLE_TIMEOUT));

  for (genvar i = 0; i < N; i++) begin : g_lane
    debug_tx_arbiter_lane #(.IDW(IDW), .LANE(i)) u_lane (
      .data_st_i (data_st),
      .gnt_i     (gid_q),
      .tx_rdy_i  (tx_rdy),
      .req_rdy_o (req_rdy[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= IDW'(N - 1);
      gid_q      <= '0;
      byte_cnt_q <= 8'd0;
      idle_cnt_q <= 8'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pick_vld) begin
            gid_q      <= pick_id;
            byte_cnt_q <= 8'd0;
            idle_cnt_q <= 8'd0;
            state_q    <= TAG_EN ? S_TAG : S_DATA;
          end
        end
        S_TAG: begin
          if (tx_rdy) state_q <= S_DATA;
        end
        S_DATA: begin
          if (xfer) byte_cnt_q <= byte_cnt_d;
          idle_cnt_q <= sel_vld ? 8'd0 : idle_cnt_d;
          if (rel_xfer || rel_idle) begin
            state_q <= S_IDLE;
            ptr_q   <= gid_q;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign grant_id = gid_q;
endmodule

// File: tb/tb_debug_tx_arbiter.sv
// Bench for debug_tx_arbiter: directed message scenarios plus random traffic,
// checked every cycle against a message-level reference model.

module tb_debug_tx_arbiter;
  localparam int N  = 4;
  localparam int MB = 4;
  localparam int TO = 16;

  typedef logic [7:0] bq_t[$];

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req_vld = '0;
  logic [8*N-1:0] req_dat = '0;
  logic [N-1:0]   req_rdy;
  logic           tx_vld;
  logic [7:0]     tx_dat;
  logic           tx_rdy = 1'b0;
  logic           busy;
  logic [1:0]     grant_id;

  always #5 clk = ~clk;

  debug_tx_arbiter #(.IDW(2), .MAX_BURST(MB), .IDLE_TIMEOUT(TO), .TAG_EN(1'b1), .EOL(8'h0A)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_dat(req_dat), .req_rdy(req_rdy),
    .tx_vld(tx_vld), .tx_dat(tx_dat), .tx_rdy(tx_rdy), .busy(busy), .grant_id(grant_id)
  );

  int  vectors = 0, miscompares = 0;
  int  src_q[N][$];
  bit  cur_vld[N];
  int  pause_left[N];
  bq_t txlog, exp_log;
  int  m_owner, m_ptr, m_gid, m_sent, m_quiet;
  bit  m_tag;
  int  rdy_mode = 0, gap_pct = 0, txdata = 0, pushed = 0;
  bit  prev_hold;
  logic [7:0] prev_dat;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_log(string tag, bq_t exp);
    int n;
    chk({tag, "_len"}, txlog.size(), exp.size());
    n = (txlog.size() < exp.size()) ? txlog.size() : exp.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_b%0d", tag, i), txlog[i], exp[i]);
  endtask

  function automatic logic [7:0] front(int i);
    int t;
    t = src_q[i][0];
    return t[7:0];
  endfunction

  // Sources: hold valid until accepted; values >= 256 are pause tokens.
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (!cur_vld[i]) begin
        if (pause_left[i] == 0 && src_q[i].size() > 0 && src_q[i][0] >= 256) begin
          pause_left[i] = src_q[i][0] - 256;
          void'(src_q[i].pop_front());
        end
        if (pause_left[i] > 0) pause_left[i]--;
        else if (src_q[i].size() > 0 && src_q[i][0] < 256 && $urandom_range(99) >= gap_pct)
          cur_vld[i] = 1'b1;
      end
      req_vld[i] = cur_vld[i];
      if (cur_vld[i]) req_dat[8*i +: 8] = front(i);
      else            req_dat[8*i +: 8] = 8'($urandom);
    end
    case (rdy_mode)
      0:       tx_rdy = 1'b1;
      1:       tx_rdy = ~tx_rdy;
      default: tx_rdy = 1'($urandom_range(1));
    endcase
  endtask

  task automatic tick();
    logic         ev;
    logic [7:0]   ed;
    logic [N-1:0] er;
    bit           acc[N];
    int           o;
    bit           rel;
    @(negedge clk);
    ev = 1'b0; ed = 8'h00; er = '0; o = m_owner;
    if (o >= 0) begin
      if (m_tag) begin ev = 1'b1; ed = 8'h80 | 8'(o); end
      else begin ev = req_vld[o]; ed = req_dat[8*o +: 8]; er[o] = tx_rdy; end
    end
    chk("tx_vld", tx_vld, ev);
    if (ev) chk("tx_dat", tx_dat, ed);
    chk("req_rdy", req_rdy, er);
    chk("busy", busy, (o >= 0));
    chk("grant_id", grant_id, m_gid);
    if (prev_hold) begin
      chk("hold_vld", tx_vld, 1);
      chk("hold_dat", tx_dat, prev_dat);
    end
    prev_hold = tx_vld && !tx_rdy;
    prev_dat  = tx_dat;
    if (tx_vld && tx_rdy) txlog.push_back(tx_dat);
    if (o >= 0 && !m_tag && tx_vld && tx_rdy) txdata++;
    for (int i = 0; i < N; i++) acc[i] = cur_vld[i] && er[i];
    rel = 1'b0;
    if (o < 0) begin
      for (int k = 1; k <= N; k++)
        if (m_owner < 0 && cur_vld[(m_ptr + k) % N]) begin
          m_owner = (m_ptr + k) % N;
          m_gid = m_owner; m_sent = 0; m_quiet = 0; m_tag = 1'b1;
        end
    end else if (m_tag) begin
      if (tx_rdy) m_tag = 1'b0;
    end else if (req_vld[o] && tx_rdy) begin
      m_sent++; m_quiet = 0;
      rel = (ed == 8'h0A) || (m_sent == MB);
    end else if (req_vld[o]) begin
      m_quiet = 0;
    end else begin
      m_quiet++;
      rel = (m_quiet == TO);
    end
    if (rel) begin m_ptr = o; m_owner = -1; end
    @(posedge clk); #1;
    for (int i = 0; i < N; i++)
      if (acc[i]) begin void'(src_q[i].pop_front()); cur_vld[i] = 1'b0; end
    drive();
  endtask

  function automatic bit all_quiet();
    bit q;
    q = (m_owner < 0);
    for (int i = 0; i < N; i++)
      if (src_q[i].size() != 0 || cur_vld[i] || pause_left[i] != 0) q = 1'b0;
    return q;
  endfunction

  task automatic run_idle(string tag, int bound);
    int n;
    bit done;
    n = 0; done = 1'b0;
    while (!done && n < bound) begin
      tick();
      n++;
      done = all_quiet();
    end
    chk({tag, "_done"}, done, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_tx_vld", tx_vld, 0);
    chk("rst_tx_dat", tx_dat, 0);
    chk("rst_req_rdy", req_rdy, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant_id", grant_id, 0);
    m_owner = -1; m_ptr = N - 1; m_gid = 0; m_tag = 1'b0; m_sent = 0; m_quiet = 0;
    prev_hold = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, waited;
    #1;
    do_reset();

    // "hi\n" from requester 0
    rdy_mode = 0; gap_pct = 0;
    src_q[0] = {8'h68, 8'h69, 8'h0A};
    txlog.delete(); drive();
    run_idle("hi", 100);
    exp_log = {8'h80, 8'h68, 8'h69, 8'h0A};
    chk_log("hi", exp_log);

    // requesters 1 and 2 contend from reset
    do_reset();
    src_q[1] = {8'h41, 8'h0A};
    src_q[2] = {8'h41, 8'h0A};
    txlog.delete(); drive();
    run_idle("rr", 100);
    exp_log = {8'h81, 8'h41, 8'h0A, 8'h82, 8'h41, 8'h0A};
    chk_log("rr", exp_log);
    src_q[1] = {8'h42, 8'h0A};
    src_q[2] = {8'h43, 8'h0A};
    txlog.delete(); drive();
    run_idle("rr2", 100);
    exp_log = {8'h81, 8'h42, 8'h0A, 8'h82, 8'h43, 8'h0A};
    chk_log("rr2", exp_log);

    // burst split on requester 3, then timeout release
    src_q[3] = {8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
    txlog.delete(); drive();
    run_idle("burst", 200);
    exp_log = {8'h83, 8'h30, 8'h31, 8'h32, 8'h33, 8'h83, 8'h34, 8'h35};
    chk_log("burst", exp_log);

    // tx_rdy toggling every cycle
    rdy_mode = 1;
    src_q[0] = {8'h68, 8'h69, 8'h0A};
    txlog.delete(); drive();
    run_idle("toggle", 100);
    exp_log = {8'h80, 8'h68, 8'h69, 8'h0A};
    chk_log("toggle", exp_log);

    // pause just under and exactly at the idle timeout
    rdy_mode = 0;
    src_q[0] = {8'h61, 8'h62, 256 + TO - 1, 8'h63, 8'h0A};
    txlog.delete(); drive();
    run_idle("pause15", 200);
    exp_log = {8'h80, 8'h61, 8'h62, 8'h63, 8'h0A};
    chk_log("pause15", exp_log);
    src_q[0] = {8'h61, 8'h62, 256 + TO, 8'h63, 8'h0A};
    txlog.delete(); drive();
    run_idle("pause16", 200);
    exp_log = {8'h80, 8'h61, 8'h62, 8'h80, 8'h63, 8'h0A};
    chk_log("pause16", exp_log);

    // reset in the middle of a message
    src_q[0] = {8'h61, 8'h62, 8'h63, 8'h64, 8'h0A};
    txlog.delete(); drive();
    waited = 0;
    while (txlog.size() < 3 && waited < 20) begin tick(); waited++; end
    chk("midrst_reached", txlog.size(), 3);
    do_reset();
    txlog.delete();
    run_idle("midrst", 100);
    exp_log = {8'h80, 8'h63, 8'h64, 8'h0A};
    chk_log("midrst", exp_log);

    // random traffic
    rdy_mode = 2; gap_pct = 25; txdata = 0; pushed = 0;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) begin
        nb = $urandom_range(12, 1);
        for (int j = 0; j < nb; j++) begin
          if ($urandom_range(9) == 0) src_q[i].push_back(256 + $urandom_range(20, 1));
          src_q[i].push_back(($urandom_range(7) == 0) ? 8'h0A : $urandom_range(255));
          pushed++;
        end
      end
      run_idle("rand", 4000);
    end
    chk("rand_bytes", txdata, pushed);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
